// File: rtl/writeback_control.sv
// Execute/memory/writeback pipeline tail with a per-register pending-write
// scoreboard. Decode is stalled while any source register still has a write
// in flight; results become visible only after their writeback cycle closes.
module writeback_control (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [19:0] issue_instruction,
    input  logic [3:0]  ReadAddressRF1,
    input  logic [3:0]  ReadAddressRF2,
    input  logic [15:0] alu_result,
    input  logic [15:0] mem_data,
    output logic        stall,
    output logic        WriteEnable,
    output logic [3:0]  WriteAddress,
    output logic [15:0] WriteData
);

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b1100;
    localparam logic [3:0] OP_LOAD  = 4'b1011;

    logic [3:0]  opcode;
    logic [3:0]  dest;
    logic        is_writer;
    logic        is_load;
    logic        accept_write;
    logic        unused_bits;

    // Stage registers; WB dest/data double as the register-file write port.
    logic        ex_valid;
    logic        ex_load;
    logic [3:0]  ex_dest;
    logic        mem_valid;
    logic        mem_load;
    logic [3:0]  mem_dest;
    logic [15:0] mem_result;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [15:0] wb_data;

    // Pending-write counters, one per architectural register.
    logic [1:0]  pending [16];
    logic [15:0] inc_vec;
    logic [15:0] dec_vec;

    assign opcode      = issue_instruction[19:16];
    assign dest        = issue_instruction[15:12];
    assign unused_bits = ^issue_instruction[11:0];

    assign is_writer    = (opcode != OP_NOP) && (opcode != OP_STORE);
    assign is_load      = (opcode == OP_LOAD);
    assign stall        = (pending[ReadAddressRF1] != 2'd0) || (pending[ReadAddressRF2] != 2'd0);
    // Non-writing offers never need to travel down the pipe, so they enter EX as bubbles.
    assign accept_write = issue_valid && !stall && is_writer;

    assign WriteEnable  = wb_valid;
    assign WriteAddress = wb_dest;
    assign WriteData    = wb_data;

    // Advance the EX -> MEM -> WB pipe every cycle; bubbles carry zero dest/data into WB.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_load    <= 1'b0;
            ex_dest    <= 4'h0;
            mem_valid  <= 1'b0;
            mem_load   <= 1'b0;
            mem_dest   <= 4'h0;
            mem_result <= 16'h0000;
            wb_valid   <= 1'b0;
            wb_dest    <= 4'h0;
            wb_data    <= 16'h0000;
        end else begin
            ex_valid   <= accept_write;
            ex_load    <= accept_write && is_load;
            ex_dest    <= accept_write ? dest : 4'h0;
            mem_valid  <= ex_valid;
            mem_load   <= ex_load;
            mem_dest   <= ex_dest;
            mem_result <= alu_result;
            wb_valid   <= mem_valid;
            wb_dest    <= mem_valid ? mem_dest : 4'h0;
            if (!mem_valid) begin
                wb_data <= 16'h0000;
            end else if (mem_load) begin
                wb_data <= mem_data;
            end else begin
                wb_data <= mem_result;
            end
        end
    end

    // Decode which counters go up (new writer) and down (write completing) at this edge.
    always_comb begin
        inc_vec = 16'h0000;
        dec_vec = 16'h0000;
        if (accept_write) begin
            inc_vec[dest] = 1'b1;
        end
        if (WriteEnable) begin
            dec_vec[WriteAddress] = 1'b1;
        end
    end

    // Update the scoreboard; a simultaneous up and down on one register cancels out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                pending[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    pending[i] <= pending[i] + 2'd1;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    pending[i] <= pending[i] - 2'd1;
                end
            end
        end
    end

    // Catch a counter wrapping past three writers or dropping below zero.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    assert (pending[i] != 2'd3);
                end
                if (dec_vec[i] && !inc_vec[i]) begin
                    assert (pending[i] != 2'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_writeback_control.sv
// Randomised scoreboard bench for writeback_control. Every accepted writer is
// queued with the edge it was accepted on; a monitor pops the queue whenever a
// write appears and also checks stall against an in-flight-write model.
module tb_writeback_control;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [19:0] issue_instruction = 20'h0;
    logic [3:0]  ReadAddressRF1 = 4'h0;
    logic [3:0]  ReadAddressRF2 = 4'h0;
    logic [15:0] alu_result = 16'h0;
    logic [15:0] mem_data = 16'h0;
    logic        stall;
    logic        WriteEnable;
    logic [3:0]  WriteAddress;
    logic [15:0] WriteData;

    typedef struct {
        logic [3:0] dest;
        bit         isLoad;
        int         acceptEdge;
    } wr_t;

    wr_t         expectQ[$];
    wr_t         inflight[$];
    logic [15:0] aluHist [int];
    logic [15:0] memHist [int];
    int          edgeCount = 0;
    int          total = 0;
    int          bad = 0;

    writeback_control dut (
        .clock(clock),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_instruction(issue_instruction),
        .ReadAddressRF1(ReadAddressRF1),
        .ReadAddressRF2(ReadAddressRF2),
        .alu_result(alu_result),
        .mem_data(mem_data),
        .stall(stall),
        .WriteEnable(WriteEnable),
        .WriteAddress(WriteAddress),
        .WriteData(WriteData)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Number the rising edges so accepts and writes can be placed in time
    always @(posedge clock) edgeCount++;

    // A register is busy from its accept edge a until edge a+3 closes its write cycle
    function automatic bit modelPending(logic [3:0] r, int e);
        foreach (inflight[i]) begin
            if (inflight[i].dest == r && inflight[i].acceptEdge <= e && e <= inflight[i].acceptEdge + 2)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edgeCount);
        end
    endtask

    // Drive one cycle of inputs right now and record what the model expects from it
    task automatic driveInputs(bit v, logic [3:0] op, logic [3:0] dst, logic [3:0] r1, logic [3:0] r2,
                               logic [15:0] a, logic [15:0] m);
        int  e = edgeCount;
        wr_t w;
        issue_valid       = v;
        issue_instruction = {op, dst, 12'($urandom)};
        ReadAddressRF1    = r1;
        ReadAddressRF2    = r2;
        alu_result        = a;
        mem_data          = m;
        aluHist[e + 1]    = a;
        memHist[e + 1]    = m;
        while (inflight.size() > 0 && inflight[0].acceptEdge + 2 < e) void'(inflight.pop_front());
        if (!reset && v && !(modelPending(r1, e) || modelPending(r2, e)) && op != 4'h0 && op != 4'hC) begin
            w.dest       = dst;
            w.isLoad     = (op == 4'hB);
            w.acceptEdge = e + 1;
            expectQ.push_back(w);
            inflight.push_back(w);
        end
    endtask

    task automatic applyStimulus(bit v, logic [3:0] op, logic [3:0] dst, logic [3:0] r1, logic [3:0] r2,
                                 logic [15:0] a, logic [15:0] m);
        @(posedge clock);
        #2;
        driveInputs(v, op, dst, r1, r2, a, m);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 4'h0, 4'hF, 4'hF, 16'($urandom), 16'($urandom));
    endtask

    // Assert reset mid-cycle, discard everything the model had in flight
    task automatic doReset();
        @(posedge clock);
        #2;
        reset       = 1'b1;
        issue_valid = 1'b0;
        expectQ.delete();
        inflight.delete();
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: compare stall every cycle, pop the scoreboard whenever a write shows up
    task automatic checkOutput();
        int  e = edgeCount;
        wr_t w;
        check("stall", stall, reset ? 1'b0 : (modelPending(ReadAddressRF1, e) || modelPending(ReadAddressRF2, e)));
        if (WriteEnable) begin
            total++;
            if (expectQ.size() == 0) begin
                bad++;
                $display("[TB] FAIL spurious_write: got addr %0h data %0h expected no write at edge %0d",
                         WriteAddress, WriteData, e);
            end else begin
                w = expectQ.pop_front();
                check("write_edge", e, w.acceptEdge + 2);
                check("write_addr", WriteAddress, w.dest);
                check("write_data", WriteData, w.isLoad ? memHist[w.acceptEdge + 2] : aluHist[w.acceptEdge + 1]);
            end
        end else begin
            check("idle_addr", WriteAddress, 4'h0);
            check("idle_data", WriteData, 16'h0);
            total++;
            if (expectQ.size() > 0 && expectQ[0].acceptEdge + 2 <= e) begin
                bad++;
                $display("[TB] FAIL missing_write: got no write expected addr %0h at edge %0d",
                         expectQ[0].dest, expectQ[0].acceptEdge + 2);
                void'(expectQ.pop_front());
            end
        end
    endtask

    always @(negedge clock) checkOutput();

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        // First accept on the very first edge after reset release: ALU r3 <- 00AA
        driveInputs(1'b1, 4'h1, 4'd3, 4'd8, 4'd9, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 4'h0, 4'h0, 4'd3, 4'd9, 16'h00AA, 16'h5555);
        idle(3);
        // Load r5: alu_result FFFF in EX must be replaced by mem_data 1234 in MEM
        applyStimulus(1'b1, 4'hB, 4'd5, 4'd8, 4'd9, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 4'h0, 4'h0, 4'd5, 4'd9, 16'hFFFF, 16'h0000);
        applyStimulus(1'b0, 4'h0, 4'h0, 4'd5, 4'd9, 16'h0000, 16'h1234);
        idle(2);
        // Store and nop never write and never mark anything pending
        applyStimulus(1'b1, 4'hC, 4'd6, 4'd8, 4'd9, 16'h1111, 16'h2222);
        applyStimulus(1'b1, 4'h0, 4'd6, 4'd6, 4'd9, 16'h3333, 16'h4444);
        applyStimulus(1'b1, 4'h1, 4'd10, 4'd6, 4'd6, 16'h0BCD, 16'h0000);
        idle(3);
        // Dependent reader of r2 stalls until r2's write completes
        applyStimulus(1'b1, 4'h2, 4'd2, 4'd8, 4'd9, 16'h0000, 16'h0000);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'h3, 4'd11, 4'd2, 4'd9, 16'(16'h0100 + i), 16'h0000);
        idle(3);
        // Back-to-back writers to r7, then watch the r7 stall release
        applyStimulus(1'b1, 4'h2, 4'd7, 4'd8, 4'd9, 16'h0000, 16'h0000);
        applyStimulus(1'b1, 4'h4, 4'd7, 4'd8, 4'd9, 16'h0077, 16'h0000);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 4'h0, 4'h0, 4'd7, 4'd7, 16'(16'h0700 + i), 16'h0000);
        idle(3);
        // Randomised traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
                          4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        idle(4);
        // Three writers in flight, then reset: none of them may ever write
        applyStimulus(1'b1, 4'h1, 4'd1, 4'd12, 4'd13, 16'hA001, 16'h0000);
        applyStimulus(1'b1, 4'h1, 4'd2, 4'd12, 4'd13, 16'hA002, 16'h0000);
        applyStimulus(1'b1, 4'hB, 4'd3, 4'd12, 4'd13, 16'hA003, 16'hB003);
        doReset();
        // Every counter must read back as zero through the stall output
        for (int r = 0; r < 16; r++) applyStimulus(1'b0, 4'h0, 4'h0, 4'(r), 4'(r), 16'h0, 16'h0);
        idle(4);
        check("scoreboard_drained", expectQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
